sqroot_hs_stage: RTL

SQROOT_HS_STAGE -- requirements
Module: sqroot_hs_stage

---
 rtl/sqroot_hs_stage_pkg.sv | 23 ++
 rtl/sqroot_hs_stage_comb.sv | 45 ++++
 rtl/sqroot_hs_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sqroot_hs_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sqroot_hs_stage_pkg
// Purpose  : Shared types and constants for the handshaked square-root stage.
// Revision : 1.0 - initial release
// ============================================================================
package sqroot_hs_stage_pkg;

  // Radicand width and the root width it implies (max root is 16).
  localparam int NBITS  = 8;
  localparam int ROOT_W = NBITS / 2 + 1;

  // Settle counter width; holds SETTLE_CYCLES-1 for SETTLE_CYCLES up to 15.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } sqroot_hs_state_t;

endpackage : sqroot_hs_stage_pkg
`default_nettype wire

// File: rtl/sqroot_hs_stage_comb.sv
`default_nettype none
// ============================================================================
// Module   : sqroot_comb_NBITS8
// Purpose  : Purely combinational 8-bit integer square root with optional
//            round-to-nearest.
// Revision : 1.0 - initial release
// ============================================================================
module sqroot_comb_NBITS8
  import sqroot_hs_stage_pkg::*;
(
  input  logic [NBITS-1:0]  arg,
  input  logic              roundup,
  output logic [ROOT_W-1:0] sqroot
);

  logic [ROOT_W-1:0]   root;
  logic [ROOT_W-1:0]   trial;
  logic [2*ROOT_W-1:0] trial_sq;
  logic [2*ROOT_W-1:0] half_point;
  logic [2*ROOT_W-1:0] arg_ext;

  // Bit-serial floor root (one trial bit per step, MSB first), then round up
  // when the radicand lies beyond r*r + r, i.e. past the midpoint to (r+1)^2.
  always_comb begin
    root       = '0;
    trial      = '0;
    trial_sq   = '0;
    arg_ext    = {{(2*ROOT_W-NBITS){1'b0}}, arg};
    for (int i = ROOT_W - 2; i >= 0; i--) begin
      trial    = root | (ROOT_W'(1) << i);
      trial_sq = {{ROOT_W{1'b0}}, trial} * {{ROOT_W{1'b0}}, trial};
      if (trial_sq <= arg_ext) begin
        root = trial;
      end
    end
    half_point = ({{ROOT_W{1'b0}}, root} * {{ROOT_W{1'b0}}, root})
               + {{ROOT_W{1'b0}}, root};
    if (roundup && (arg_ext > half_point)) begin
      root = root + ROOT_W'(1);
    end
    sqroot = root;
  end

endmodule : sqroot_comb_NBITS8
`default_nettype wire

// File: rtl/sqroot_hs_stage.sv
`default_nettype none
// ============================================================================
// Module   : sqroot_hs_stage
// Purpose  : Valid/ready wrapper around the combinational square-root core.
//            Operands are latched on accept, the core is given SETTLE_CYCLES
//            cycles to settle, and the root is held until the consumer
//            takes it.
// Revision : 1.0 - initial release
// ============================================================================
module sqroot_hs_stage
  import sqroot_hs_stage_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NBITS-1:0]  in_arg,
  input  logic              in_roundup,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] out_sqroot,
  output logic              busy,
  output logic [7:0]        result_cnt
);

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES - 1);

  sqroot_hs_state_t  state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NBITS-1:0]  arg_q, arg_d;
  logic              rnd_q, rnd_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic [7:0]        result_cnt_q, result_cnt_d;

  logic              accept;
  logic              handshake;
  logic [ROOT_W-1:0] core_root;

  // The core only ever sees the latched operand, so input wiggles while
  // settling cannot disturb the pending result.
  sqroot_comb_NBITS8 u_core (
    .arg     (arg_q),
    .roundup (rnd_q),
    .sqroot  (core_root)
  );

  assign in_ready   = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept     = in_valid & in_ready;
  assign handshake  = out_valid_q & out_ready;

  assign out_valid  = out_valid_q;
  assign out_sqroot = root_q;
  assign busy       = busy_q;
  assign result_cnt = result_cnt_q;

  // Next-state logic: accept, settle countdown, capture and hand-off.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    arg_d        = arg_q;
    rnd_d        = rnd_q;
    root_d       = root_q;
    result_cnt_d = result_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          arg_d   = in_arg;
          rnd_d   = in_roundup;
          cnt_d   = c_cnt_load;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          root_d  = core_root;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            // Consume and reload at the same edge: no idle bubble.
            arg_d   = in_arg;
            rnd_d   = in_roundup;
            cnt_d   = c_cnt_load;
            state_d = SETTLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (handshake) begin
      result_cnt_d = result_cnt_q + 8'd1;
    end

    // Status outputs are registered alongside the state they describe.
    busy_d      = (state_d == SETTLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      arg_q        <= '0;
      rnd_q        <= 1'b0;
      root_q       <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      result_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      arg_q        <= arg_d;
      rnd_q        <= rnd_d;
      root_q       <= root_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      result_cnt_q <= result_cnt_d;
    end
  end

endmodule : sqroot_hs_stage
`default_nettype wire
